// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO-buffered, LSB-first, s_tick paced.
// Parity and stop length are captured per frame when the word is popped.
module uart_tx_param #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_tick,
  input  logic                     in_valid,
  input  logic [DBIT-1:0]          in_data,
  output logic                     in_ready,
  input  logic [1:0]               cfg_parity,
  input  logic [1:0]               cfg_stop,
  output logic                     tx,
  output logic                     busy,
  output logic                     tx_done_tick,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int SW = $clog2(2 * OVERSAMPLE);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [SW-1:0] OS_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] STOP15_LAST = SW'((3 * OVERSAMPLE) / 2 - 1);
  localparam logic [SW-1:0] STOP2_LAST  = SW'(2 * OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic parity_of(input logic [DBIT-1:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

  // FIFO storage and pointers
  logic [DBIT-1:0] mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r, count_s;
  logic            ready_r;
  logic            push_s, pop_s;
  logic [DBIT-1:0] head_s;

  // Frame datapath
  state_t          state_r, state_s;
  logic [SW-1:0]   s_reg_r, s_reg_s;
  logic [NW-1:0]   n_reg_r, n_reg_s;
  logic [DBIT-1:0] b_reg_r, b_reg_s;
  logic            par_en_r, par_en_s;
  logic            par_bit_r, par_bit_s;
  logic [1:0]      stop_cfg_r, stop_cfg_s;
  logic [SW-1:0]   stop_last_s;
  logic            tx_r, tx_s;
  logic            busy_r;
  logic            done_r, done_s;

  assign head_s = mem_r[rd_ptr_r];
  assign push_s = in_valid && (count_r != FULL_CNT);
  assign pop_s  = (state_r == IDLE) && (count_r != CW'(0));

  // FIFO occupancy next value
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CW'(1);
      2'b01:   count_s = count_r - CW'(1);
      default: count_s = count_r;
    endcase
  end

  // FIFO storage needs no reset; only valid entries are ever read
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // FIFO pointers, count and ready flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      ready_r  <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      count_r <= count_s;
      ready_r <= (count_s != FULL_CNT);
    end
  end

  // Stop length in ticks for the frame in flight
  always_comb begin
    stop_last_s = STOP2_LAST;
    case (stop_cfg_r)
      2'b00:   stop_last_s = OS_LAST;
      2'b01:   stop_last_s = STOP15_LAST;
      default: stop_last_s = STOP2_LAST;
    endcase
  end

  // Next state, counters and tx level; tx_s reflects the current state and is registered
  always_comb begin
    state_s    = state_r;
    s_reg_s    = s_reg_r;
    n_reg_s    = n_reg_r;
    b_reg_s    = b_reg_r;
    par_en_s   = par_en_r;
    par_bit_s  = par_bit_r;
    stop_cfg_s = stop_cfg_r;
    done_s     = 1'b0;
    tx_s       = 1'b1;
    case (state_r)
      IDLE: begin
        tx_s = 1'b1;
        if (pop_s) begin
          state_s    = START;
          s_reg_s    = '0;
          n_reg_s    = '0;
          b_reg_s    = head_s;
          par_en_s   = ^cfg_parity;
          par_bit_s  = parity_of(head_s, cfg_parity[1]);
          stop_cfg_s = cfg_stop;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        tx_s = 1'b0;
        if (s_tick) begin
          if (s_reg_r == OS_LAST) begin
            state_s = DATA;
            s_reg_s = '0;
          end else begin
            s_reg_s = s_reg_r + SW'(1);
          end
        end else begin
          s_reg_s = s_reg_r;
        end
      end
      DATA: begin
        tx_s = b_reg_r[0];
        if (s_tick) begin
          if (s_reg_r == OS_LAST) begin
            s_reg_s = '0;
            b_reg_s = b_reg_r >> 1;
            if (n_reg_r == N_LAST) begin
              state_s = par_en_r ? PARITY : STOP;
            end else begin
              n_reg_s = n_reg_r + NW'(1);
            end
          end else begin
            s_reg_s = s_reg_r + SW'(1);
          end
        end else begin
          s_reg_s = s_reg_r;
        end
      end
      PARITY: begin
        tx_s = par_bit_r;
        if (s_tick) begin
          if (s_reg_r == OS_LAST) begin
            state_s = STOP;
            s_reg_s = '0;
          end else begin
            s_reg_s = s_reg_r + SW'(1);
          end
        end else begin
          s_reg_s = s_reg_r;
        end
      end
      STOP: begin
        tx_s = 1'b1;
        if (s_tick) begin
          if (s_reg_r == stop_last_s) begin
            state_s = IDLE;
            s_reg_s = '0;
            done_s  = 1'b1;
          end else begin
            s_reg_s = s_reg_r + SW'(1);
          end
        end else begin
          s_reg_s = s_reg_r;
        end
      end
      default: begin
        state_s = IDLE;
        tx_s    = 1'b1;
      end
    endcase
  end

  // Frame state register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      s_reg_r    <= '0;
      n_reg_r    <= '0;
      b_reg_r    <= '0;
      par_en_r   <= 1'b0;
      par_bit_r  <= 1'b0;
      stop_cfg_r <= 2'b00;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      s_reg_r    <= s_reg_s;
      n_reg_r    <= n_reg_s;
      b_reg_r    <= b_reg_s;
      par_en_r   <= par_en_s;
      par_bit_r  <= par_bit_s;
      stop_cfg_r <= stop_cfg_s;
      tx_r       <= tx_s;
      busy_r     <= (state_s != IDLE);
      done_r     <= done_s;
    end
  end

  assign tx           = tx_r;
  assign busy         = busy_r;
  assign tx_done_tick = done_r;
  assign in_ready     = ready_r;
  assign fifo_count   = count_r;

endmodule

// File: tb/tb_uart_tx_param.sv
// Randomised bench for uart_tx_param against a frame-level reference model:
// each queued word expands into a list of expected line levels, one per s_tick.
module tb_uart_tx_param;

  localparam int DBIT       = 8;
  localparam int OVERSAMPLE = 16;
  localparam int DEPTH      = 4;
  localparam int CW         = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset, s_tick, in_valid;
  logic [DBIT-1:0] in_data;
  logic            in_ready;
  logic [1:0]      cfg_parity, cfg_stop;
  logic            tx, busy, tx_done_tick;
  logic [CW-1:0]   fifo_count;

  int total = 0;
  int bad   = 0;

  uart_tx_param #(.DBIT(DBIT), .OVERSAMPLE(OVERSAMPLE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .cfg_parity(cfg_parity), .cfg_stop(cfg_stop), .tx(tx),
    .busy(busy), .tx_done_tick(tx_done_tick), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  bit [DBIT-1:0] q[$];
  bit            ticks[$];
  bit            active = 1'b0;
  int            frames_done = 0;

  task automatic build_frame(input bit [DBIT-1:0] w, input bit [1:0] par, input bit [1:0] stp);
    int stop_len;
    bit pbit;
    ticks.delete();
    for (int i = 0; i < OVERSAMPLE; i++) ticks.push_back(1'b0);
    for (int b = 0; b < DBIT; b++)
      for (int i = 0; i < OVERSAMPLE; i++) ticks.push_back(w[b]);
    if (par == 2'd1 || par == 2'd2) begin
      pbit = ($countones(w) % 2 == 1);
      if (par == 2'd2) pbit = !pbit;
      for (int i = 0; i < OVERSAMPLE; i++) ticks.push_back(pbit);
    end
    case (stp)
      2'd0:    stop_len = OVERSAMPLE;
      2'd1:    stop_len = (3 * OVERSAMPLE) / 2;
      default: stop_len = 2 * OVERSAMPLE;
    endcase
    for (int i = 0; i < stop_len; i++) ticks.push_back(1'b1);
  endtask

  // Model update on each edge from pre-edge inputs, then compare just after the edge
  always @(posedge clk) begin
    bit exp_tx, exp_done;
    int pre_size;
    exp_done = 1'b0;
    exp_tx   = 1'b1;
    if (reset) begin
      q.delete();
      ticks.delete();
      active = 1'b0;
    end else begin
      pre_size = q.size();
      if (active) begin
        if (s_tick) begin
          exp_tx = ticks.pop_front();
          if (ticks.size() == 0) begin
            active   = 1'b0;
            exp_done = 1'b1;
            frames_done++;
          end
        end else begin
          exp_tx = ticks[0];
        end
      end else if (pre_size > 0) begin
        build_frame(q.pop_front(), cfg_parity, cfg_stop);
        active = 1'b1;
      end
      if (in_valid && pre_size < DEPTH) q.push_back(in_data);
    end
    #1;
    check("tx", {31'd0, tx}, {31'd0, exp_tx});
    check("busy", {31'd0, busy}, {31'd0, active});
    check("done", {31'd0, tx_done_tick}, {31'd0, exp_done});
    check("count", {{(32-CW){1'b0}}, fifo_count}, q.size());
    check("ready", {31'd0, in_ready}, {31'd0, (q.size() < DEPTH)});
  end

  initial begin
    int freeze;
    freeze     = 0;
    reset      = 1'b1;
    s_tick     = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    cfg_parity = 2'b00;
    cfg_stop   = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    // phase 0: tick every clk; 1: sparse ticks with resets; 2: sparse ticks with long freezes
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 4000; c++) begin
        @(negedge clk);
        s_tick     = (ph == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
        in_valid   = ($urandom_range(0, 3) != 0);
        in_data    = DBIT'($urandom);
        cfg_parity = 2'($urandom);
        cfg_stop   = 2'($urandom);
        reset      = (ph == 1) && (c % 1300 == 700);
        if (ph == 2 && c % 900 == 450) freeze = 50;
        if (freeze > 0) begin
          s_tick = 1'b0;
          freeze--;
        end
      end
    end
    @(negedge clk);
    check("frames_seen", {31'd0, (frames_done > 10)}, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
